// File: rtl/hex_scan_controller_pkg.sv
// Shared widths, FSM state type and active-low seven-segment patterns.
// Segment bit0 = a .. bit6 = g; a 0 lights the segment.
package hex_pkg;
    localparam int NIB_W = 4;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {IDLE, SCAN} hex_scan_state_t;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F = 7'h0E;
endpackage

// File: rtl/hex_scan_controller_if.sv
// Load/status/display bundle between the datapath, the scan controller and the HEX pins.
interface hex_scan_controller_if
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6
);
    logic                                  load;
    logic [NUM_DIGITS-1:0][NIB_W-1:0]      value;
    logic                                  busy;
    logic                                  done;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]      hex_out;

    modport master (output load, output value, input busy, input done, input hex_out);
    modport slave  (input load, input value, output busy, output done, output hex_out);
endinterface

// File: rtl/hex_decoder.sv
// Team hex-to-seven-segment decoder: nibble MSB at port index 0, active-low segments.
module hex_decoder
    import hex_pkg::*;
(
    input  logic [0:NIB_W-1] i_nib,
    output logic [SEG_W-1:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/hex_scan_controller.sv
// Shares one hex_decoder across NUM_DIGITS displays: captures a value on load,
// then decodes one nibble per cycle MSD first into held per-digit registers.
module hex_scan_controller
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int BLANK_LEADING = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_scan_controller_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    hex_scan_state_t                    r_state, w_state_nxt;
    logic [IDX_W-1:0]                   r_idx;
    logic [NUM_DIGITS-1:0][NIB_W-1:0]   r_shadow;
    logic                               r_seen_nz;
    logic                               r_done;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]   r_hex;

    logic [NIB_W-1:0]                   w_nib;
    logic [SEG_W-1:0]                   w_seg;
    logic                               w_last;
    logic                               w_blank;

    assign w_nib   = r_shadow[r_idx];
    assign w_last  = (r_idx == '0);
    // Digit 0 always shows, so a zero value still reads "0".
    assign w_blank = (BLANK_LEADING != 0) && (w_nib == '0) && !r_seen_nz && !w_last;

    hex_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.load) w_state_nxt = SCAN;
            SCAN:    if (w_last)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_shadow  <= '0;
            r_seen_nz <= 1'b0;
            r_done    <= 1'b0;
            r_hex     <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_shadow  <= bus.value;
                        r_idx     <= IDX_W'(NUM_DIGITS - 1);
                        r_seen_nz <= 1'b0;
                    end
                end
                SCAN: begin
                    r_hex[r_idx] <= w_blank ? SEG_BLANK : w_seg;
                    r_seen_nz    <= r_seen_nz | (w_nib != '0);
                    // Leaving SCAN on digit 0 keeps idx from wrapping.
                    if (w_last) r_done <= 1'b1;
                    else        r_idx  <= r_idx - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state == SCAN);
    assign bus.done    = r_done;
    assign bus.hex_out = r_hex;
endmodule
